// File: rtl/alu_decode_pkg.sv
// Shared control header for the ID stage: ALU control encodings, RV32I opcodes,
// decode-stage state encodings and small decode helpers.
package alu_decode_pkg;

    localparam int XLEN = 32;

    // The ALU range-checks BEQ..BGEU, so those six codes must stay contiguous and ordered.
    localparam logic [4:0] ALUCTRL_ADD   = 5'd0;
    localparam logic [4:0] ALUCTRL_SUB   = 5'd1;
    localparam logic [4:0] ALUCTRL_SLL   = 5'd2;
    localparam logic [4:0] ALUCTRL_SLT   = 5'd3;
    localparam logic [4:0] ALUCTRL_SLTU  = 5'd4;
    localparam logic [4:0] ALUCTRL_XOR   = 5'd5;
    localparam logic [4:0] ALUCTRL_SRL   = 5'd6;
    localparam logic [4:0] ALUCTRL_SRA   = 5'd7;
    localparam logic [4:0] ALUCTRL_OR    = 5'd8;
    localparam logic [4:0] ALUCTRL_AND   = 5'd9;
    localparam logic [4:0] ALUCTRL_BEQ   = 5'd10;
    localparam logic [4:0] ALUCTRL_BNE   = 5'd11;
    localparam logic [4:0] ALUCTRL_BLT   = 5'd12;
    localparam logic [4:0] ALUCTRL_BGE   = 5'd13;
    localparam logic [4:0] ALUCTRL_BLTU  = 5'd14;
    localparam logic [4:0] ALUCTRL_BGEU  = 5'd15;
    localparam logic [4:0] ALUCTRL_AUIPC = 5'd16;
    localparam logic [4:0] ALUCTRL_JAL   = 5'd17;
    localparam logic [4:0] ALUCTRL_JALR  = 5'd18;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Shared funct3 map of OP and OP-IMM; alt is funct7[5] where it selects SUB/SRA.
    function automatic logic [4:0] alu_op_map(input logic [2:0] funct3, input logic alt);
        logic [4:0] op;
        case (funct3)
            3'b000:  op = alt ? ALUCTRL_SUB : ALUCTRL_ADD;
            3'b001:  op = ALUCTRL_SLL;
            3'b010:  op = ALUCTRL_SLT;
            3'b011:  op = ALUCTRL_SLTU;
            3'b100:  op = ALUCTRL_XOR;
            3'b101:  op = alt ? ALUCTRL_SRA : ALUCTRL_SRL;
            3'b110:  op = ALUCTRL_OR;
            default: op = ALUCTRL_AND;
        endcase
        return op;
    endfunction

    function automatic logic reads_rs1(input logic [6:0] opcode);
        return !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opcode);
        return (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/alu_decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: picks the I/S/B/U/J format from the
// opcode and sign-extends to 32 bits.
module alu_imm_gen
    import alu_decode_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'h000};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage: produces ALU controls, operands selects and
// register/memory controls, with a one-bubble load-use interlock and illegal-opcode halt.
module alu_decode_stage
    import alu_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [4:0]  alu_ctrl,
    output logic        alu_immsrc,
    output logic        alu_pcsrc,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] dec_imm;
    logic [4:0]  dec_ctrl;
    logic        dec_immsrc;
    logic        dec_pcsrc;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_illegal;
    logic        dec_rs1_zero;
    logic [2:0]  br_idx;
    logic        load_use;
    logic        accept;

    state_e      state_q, state_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [4:0]  alu_ctrl_q, alu_ctrl_d;
    logic        alu_immsrc_q, alu_immsrc_d;
    logic        alu_pcsrc_q, alu_pcsrc_d;
    logic [31:0] imm_q, imm_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        illegal_q, illegal_d;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];
    assign in_rs1 = if_instr[19:15];
    assign in_rs2 = if_instr[24:20];
    assign in_rd  = if_instr[11:7];

    alu_imm_gen u_imm_gen (
        .instr (if_instr),
        .imm   (dec_imm)
    );

    // Branch funct3 {000,001,100..111} folds onto offsets 0..5 from ALUCTRL_BEQ.
    assign br_idx = funct3[2] ? ({1'b0, funct3[1:0]} + 3'd2) : {2'b00, funct3[0]};

    always_comb begin
        dec_ctrl      = ALUCTRL_ADD;
        dec_immsrc    = 1'b0;
        dec_pcsrc     = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_illegal   = 1'b0;
        dec_rs1_zero  = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec_ctrl      = alu_op_map(funct3, funct7[5]);
                    dec_reg_write = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
                    (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_ctrl      = alu_op_map(funct3, (funct3 == 3'b101) && funct7[5]);
                    dec_immsrc    = 1'b1;
                    dec_reg_write = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (funct3 == 3'b011 || funct3[2:1] == 2'b11) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_immsrc    = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_mem_read  = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3[2] || funct3 == 3'b011) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_immsrc    = 1'b1;
                    dec_mem_write = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (funct3[2:1] == 2'b01) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_ctrl = ALUCTRL_BEQ + {2'b00, br_idx};
                end
            end
            OPC_LUI: begin
                dec_immsrc    = 1'b1;
                dec_reg_write = 1'b1;
                dec_rs1_zero  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_ctrl      = ALUCTRL_AUIPC;
                dec_pcsrc     = 1'b1;
                dec_immsrc    = 1'b1;
                dec_reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec_ctrl      = ALUCTRL_JAL;
                dec_pcsrc     = 1'b1;
                dec_immsrc    = 1'b1;
                dec_reg_write = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 != 3'b000) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_ctrl      = ALUCTRL_JALR;
                    dec_pcsrc     = 1'b1;
                    dec_immsrc    = 1'b1;
                    dec_reg_write = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign load_use = (state_q == ST_RUN) && id_valid_q && mem_read_q && (rd_q != 5'd0) &&
                      ex_ready && if_valid &&
                      ((reads_rs1(opcode) && in_rs1 == rd_q) ||
                       (reads_rs2(opcode) && in_rs2 == rd_q));

    // STALL is the bubble cycle itself: the held fetch is taken there, giving exactly one bubble.
    assign if_ready = rst_n && (state_q == ST_RUN || state_q == ST_STALL) && !flush &&
                      (!id_valid_q || ex_ready) && !load_use;
    assign accept   = if_valid && if_ready;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (load_use)
                        state_d = ST_STALL;
                    else if (accept && dec_illegal)
                        state_d = ST_HALT;
                end
                ST_STALL: state_d = (accept && dec_illegal) ? ST_HALT : ST_RUN;
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_immsrc_d = alu_immsrc_q;
        alu_pcsrc_d  = alu_pcsrc_q;
        imm_d        = imm_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        illegal_d    = illegal_q;
        if (flush) begin
            id_valid_d = 1'b0;
            illegal_d  = 1'b0;
        end else if (accept) begin
            id_valid_d   = 1'b1;
            id_pc_d      = if_pc;
            alu_ctrl_d   = dec_ctrl;
            alu_immsrc_d = dec_immsrc;
            alu_pcsrc_d  = dec_pcsrc;
            imm_d        = dec_imm;
            rs1_d        = dec_rs1_zero ? 5'd0 : in_rs1;
            rs2_d        = in_rs2;
            rd_d         = in_rd;
            reg_write_d  = dec_reg_write;
            mem_read_d   = dec_mem_read;
            mem_write_d  = dec_mem_write;
            illegal_d    = dec_illegal;
        end else if (ex_ready) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            alu_ctrl_q   <= ALUCTRL_ADD;
            alu_immsrc_q <= 1'b0;
            alu_pcsrc_q  <= 1'b0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_immsrc_q <= alu_immsrc_d;
            alu_pcsrc_q  <= alu_pcsrc_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            illegal_q    <= illegal_d;
        end
    end

    assign id_valid   = id_valid_q;
    assign id_pc      = id_pc_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign alu_immsrc = alu_immsrc_q;
    assign alu_pcsrc  = alu_pcsrc_q;
    assign imm        = imm_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign rd         = rd_q;
    assign reg_write  = reg_write_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: an instruction-table reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_alu_decode_stage;
    import alu_decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_instr = 32'h0;
    logic [31:0] if_pc = 32'h0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  alu_ctrl;
    logic        alu_immsrc;
    logic        alu_pcsrc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, mem_read, mem_write, illegal;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    alu_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_pc(id_pc), .alu_ctrl(alu_ctrl),
        .alu_immsrc(alu_immsrc), .alu_pcsrc(alu_pcsrc), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef enum {K_R, K_IA, K_L, K_S, K_B, K_U, K_UA, K_J, K_JR, K_BAD} kind_e;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  ctrl;
        logic        immsrc, pcsrc, rw, mr, mw, ill;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        bit          chk_imm, chk_rs2, chk_rd;
    } exp_t;

    // Reference decode: an instruction-list table, then per-format operand/flag rules.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t  e;
        kind_e k;
        logic [4:0] c;
        c = ALUCTRL_ADD;
        casez ({ins[31:25], ins[14:12], ins[6:0]})
            17'b0000000_000_0110011: begin k = K_R;  c = ALUCTRL_ADD;  end
            17'b0100000_000_0110011: begin k = K_R;  c = ALUCTRL_SUB;  end
            17'b0000000_001_0110011: begin k = K_R;  c = ALUCTRL_SLL;  end
            17'b0000000_010_0110011: begin k = K_R;  c = ALUCTRL_SLT;  end
            17'b0000000_011_0110011: begin k = K_R;  c = ALUCTRL_SLTU; end
            17'b0000000_100_0110011: begin k = K_R;  c = ALUCTRL_XOR;  end
            17'b0000000_101_0110011: begin k = K_R;  c = ALUCTRL_SRL;  end
            17'b0100000_101_0110011: begin k = K_R;  c = ALUCTRL_SRA;  end
            17'b0000000_110_0110011: begin k = K_R;  c = ALUCTRL_OR;   end
            17'b0000000_111_0110011: begin k = K_R;  c = ALUCTRL_AND;  end
            17'b???????_000_0010011: begin k = K_IA; c = ALUCTRL_ADD;  end
            17'b0000000_001_0010011: begin k = K_IA; c = ALUCTRL_SLL;  end
            17'b???????_010_0010011: begin k = K_IA; c = ALUCTRL_SLT;  end
            17'b???????_011_0010011: begin k = K_IA; c = ALUCTRL_SLTU; end
            17'b???????_100_0010011: begin k = K_IA; c = ALUCTRL_XOR;  end
            17'b0000000_101_0010011: begin k = K_IA; c = ALUCTRL_SRL;  end
            17'b0100000_101_0010011: begin k = K_IA; c = ALUCTRL_SRA;  end
            17'b???????_110_0010011: begin k = K_IA; c = ALUCTRL_OR;   end
            17'b???????_111_0010011: begin k = K_IA; c = ALUCTRL_AND;  end
            17'b???????_000_0000011, 17'b???????_001_0000011, 17'b???????_010_0000011,
            17'b???????_100_0000011, 17'b???????_101_0000011: k = K_L;
            17'b???????_000_0100011, 17'b???????_001_0100011,
            17'b???????_010_0100011: k = K_S;
            17'b???????_000_1100011: begin k = K_B; c = ALUCTRL_BEQ;  end
            17'b???????_001_1100011: begin k = K_B; c = ALUCTRL_BNE;  end
            17'b???????_100_1100011: begin k = K_B; c = ALUCTRL_BLT;  end
            17'b???????_101_1100011: begin k = K_B; c = ALUCTRL_BGE;  end
            17'b???????_110_1100011: begin k = K_B; c = ALUCTRL_BLTU; end
            17'b???????_111_1100011: begin k = K_B; c = ALUCTRL_BGEU; end
            17'b??????????_0110111:  k = K_U;
            17'b??????????_0010111:  begin k = K_UA; c = ALUCTRL_AUIPC; end
            17'b??????????_1101111:  begin k = K_J;  c = ALUCTRL_JAL;   end
            17'b???????_000_1100111: begin k = K_JR; c = ALUCTRL_JALR;  end
            default:                 k = K_BAD;
        endcase
        e.pc = pc; e.ctrl = c; e.ill = (k == K_BAD);
        e.rs1 = (k == K_U) ? 5'd0 : ins[19:15];
        e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.immsrc  = k inside {K_IA, K_L, K_S, K_U, K_UA, K_J, K_JR};
        e.pcsrc   = k inside {K_UA, K_J, K_JR};
        e.rw      = k inside {K_R, K_IA, K_L, K_U, K_UA, K_J, K_JR};
        e.mr      = (k == K_L);
        e.mw      = (k == K_S);
        e.chk_rs2 = k inside {K_R, K_S, K_B};
        e.chk_rd  = e.rw;
        e.chk_imm = !(k inside {K_R, K_BAD});
        case (k)
            K_S:        e.imm = 32'($signed({ins[31:25], ins[11:7]}));
            K_B:        e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            K_U, K_UA:  e.imm = {ins[31:12], 12'h000};
            K_J:        e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default:    e.imm = 32'($signed(ins[31:20]));
        endcase
        return e;
    endfunction

    function automatic bit ref_illegal(input logic [31:0] ins);
        exp_t e;
        e = ref_decode(ins, 32'h0);
        return e.ill;
    endfunction

    // Model pipeline state: one output slot, plus a halted flag.
    exp_t m_out;
    bit   m_valid = 1'b0;
    bit   m_halt  = 1'b0;

    function automatic bit model_load_use();
        logic [6:0] opc;
        bit hit1, hit2;
        opc  = if_instr[6:0];
        hit1 = !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL}) && (if_instr[19:15] == m_out.rd);
        hit2 = (opc inside {OPC_OP, OPC_STORE, OPC_BRANCH}) && (if_instr[24:20] == m_out.rd);
        return m_valid && m_out.mr && (m_out.rd != 5'd0) && ex_ready && if_valid && (hit1 || hit2);
    endfunction

    function automatic bit model_ready();
        return rst_n && !m_halt && !flush && (!m_valid || ex_ready) && !model_load_use();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_halt  <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_halt  <= 1'b0;
        end else if (if_valid && model_ready()) begin
            m_out   <= ref_decode(if_instr, if_pc);
            m_valid <= 1'b1;
            if (ref_illegal(if_instr)) m_halt <= 1'b1;
        end else if (ex_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            checkOutput("if_ready", 32'(if_ready), 32'(model_ready()));
            checkOutput("id_valid", 32'(id_valid), 32'(m_valid));
            if (m_valid) begin
                checkOutput("id_pc",     id_pc,            m_out.pc);
                checkOutput("alu_ctrl",  32'(alu_ctrl),    32'(m_out.ctrl));
                checkOutput("immsrc",    32'(alu_immsrc),  32'(m_out.immsrc));
                checkOutput("pcsrc",     32'(alu_pcsrc),   32'(m_out.pcsrc));
                checkOutput("rs1",       32'(rs1),         32'(m_out.rs1));
                checkOutput("reg_write", 32'(reg_write),   32'(m_out.rw));
                checkOutput("mem_read",  32'(mem_read),    32'(m_out.mr));
                checkOutput("mem_write", 32'(mem_write),   32'(m_out.mw));
                checkOutput("illegal",   32'(illegal),     32'(m_out.ill));
                if (m_out.chk_imm) checkOutput("imm", imm, m_out.imm);
                if (m_out.chk_rs2) checkOutput("rs2", 32'(rs2), 32'(m_out.rs2));
                if (m_out.chk_rd)  checkOutput("rd",  32'(rd),  32'(m_out.rd));
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic exr, input logic fl);
        if_valid = v; if_instr = ins; if_pc = pc; ex_ready = exr; flush = fl;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADDI  = 32'hFFB00093;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_SRAI  = 32'h4031D213;
    localparam logic [31:0] I_LW5   = 32'h0000A283;
    localparam logic [31:0] I_ADD6  = 32'h00228333;
    localparam logic [31:0] I_LW0   = 32'h0000A003;
    localparam logic [31:0] I_ADD60 = 32'h00200333;
    localparam logic [31:0] I_BGE   = 32'hFE20DCE3;
    localparam logic [31:0] I_JAL   = 32'h010000EF;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_MUL   = 32'h023100B3;
    localparam logic [31:0] I_BAD   = 32'h0000007F;
    localparam logic [31:0] I_ADD7  = 32'h002083B3;

    initial begin
        #1;
        checkOutput("rst id_valid", 32'(id_valid), 32'd0);
        checkOutput("rst if_ready", 32'(if_ready), 32'd0);
        checkOutput("rst alu_ctrl", 32'(alu_ctrl), 32'(ALUCTRL_ADD));
        checkOutput("rst imm", imm, 32'h0);
        #20 rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1, I_ADDI, 32'h100, 1, 0); stepClock();
        checkOutput("addi ctrl", 32'(alu_ctrl), 32'(ALUCTRL_ADD));
        checkOutput("addi immsrc", 32'(alu_immsrc), 32'd1);
        checkOutput("addi imm", imm, 32'hFFFFFFFB);
        checkOutput("addi rd", 32'(rd), 32'd1);
        checkOutput("addi reg_write", 32'(reg_write), 32'd1);

        applyStimulus(1, I_SUB, 32'h104, 1, 0); stepClock();
        checkOutput("sub ctrl", 32'(alu_ctrl), 32'(ALUCTRL_SUB));
        applyStimulus(1, I_SRAI, 32'h108, 1, 0); stepClock();
        checkOutput("srai ctrl", 32'(alu_ctrl), 32'(ALUCTRL_SRA));
        checkOutput("srai shamt", 32'(imm[4:0]), 32'd3);
        checkOutput("srai valid", 32'(id_valid), 32'd1);

        applyStimulus(1, I_LW5, 32'h10C, 1, 0); stepClock();
        applyStimulus(1, I_ADD6, 32'h110, 1, 0); #1;
        checkOutput("lu ready low", 32'(if_ready), 32'd0);
        stepClock();
        checkOutput("lu bubble", 32'(id_valid), 32'd0);
        checkOutput("lu ready back", 32'(if_ready), 32'd1);
        stepClock();
        checkOutput("lu add valid", 32'(id_valid), 32'd1);
        checkOutput("lu add rs1", 32'(rs1), 32'd5);
        checkOutput("lu add ctrl", 32'(alu_ctrl), 32'(ALUCTRL_ADD));

        applyStimulus(1, I_LW0, 32'h114, 1, 0); stepClock();
        applyStimulus(1, I_ADD60, 32'h118, 1, 0); #1;
        checkOutput("x0 no stall", 32'(if_ready), 32'd1);
        stepClock();
        checkOutput("x0 add rd", 32'(rd), 32'd6);

        applyStimulus(1, I_BGE, 32'h200, 1, 0); stepClock();
        checkOutput("bge ctrl", 32'(alu_ctrl), 32'(ALUCTRL_BGE));
        checkOutput("bge imm", imm, 32'hFFFFFFF8);
        checkOutput("bge reg_write", 32'(reg_write), 32'd0);
        applyStimulus(1, I_JAL, 32'h204, 1, 0); stepClock();
        checkOutput("jal ctrl", 32'(alu_ctrl), 32'(ALUCTRL_JAL));
        checkOutput("jal pcsrc", 32'(alu_pcsrc), 32'd1);
        checkOutput("jal imm", imm, 32'h00000010);
        applyStimulus(1, I_LUI, 32'h300, 1, 0); stepClock();
        checkOutput("lui imm", imm, 32'h12345000);
        applyStimulus(1, I_SW, 32'h304, 1, 0); stepClock();
        checkOutput("sw imm", imm, 32'h00000004);

        applyStimulus(1, I_MUL, 32'h308, 1, 0); stepClock();
        checkOutput("mul illegal", 32'(illegal), 32'd1);
        applyStimulus(0, 32'h0, 32'h0, 1, 1); stepClock();

        applyStimulus(1, I_BAD, 32'h400, 1, 0); stepClock();
        checkOutput("bad illegal", 32'(illegal), 32'd1);
        checkOutput("bad valid", 32'(id_valid), 32'd1);
        checkOutput("bad reg_write", 32'(reg_write), 32'd0);
        applyStimulus(1, I_ADD7, 32'h404, 1, 0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("halt ready", 32'(if_ready), 32'd0);
            stepClock();
        end
        applyStimulus(1, I_ADD7, 32'h404, 1, 1); stepClock();
        checkOutput("flush valid", 32'(id_valid), 32'd0);
        applyStimulus(1, I_ADD7, 32'h408, 1, 0); stepClock();
        checkOutput("post flush rd", 32'(rd), 32'd7);
        checkOutput("post flush illegal", 32'(illegal), 32'd0);

        applyStimulus(1, I_ADD6, 32'h500, 1, 1); stepClock();
        checkOutput("flush drop", 32'(id_valid), 32'd0);

        applyStimulus(1, I_SUB, 32'h504, 1, 0); stepClock();
        applyStimulus(1, I_SRAI, 32'h508, 0, 0); #1;
        checkOutput("hold ready", 32'(if_ready), 32'd0);
        stepClock();
        checkOutput("hold ctrl", 32'(alu_ctrl), 32'(ALUCTRL_SUB));
        applyStimulus(1, I_SRAI, 32'h508, 1, 0); stepClock();
        checkOutput("release ctrl", 32'(alu_ctrl), 32'(ALUCTRL_SRA));

        applyStimulus(1, I_LW5, 32'h600, 1, 0); stepClock();
        applyStimulus(1, I_ADD6, 32'h604, 1, 0); stepClock();
        applyStimulus(1, I_ADD6, 32'h604, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst valid", 32'(id_valid), 32'd0);
        checkOutput("arst ready", 32'(if_ready), 32'd0);
        checkOutput("arst mem_read", 32'(mem_read), 32'd0);
        checkOutput("arst rd", 32'(rd), 32'd0);
        checkOutput("arst rs1", 32'(rs1), 32'd0);
        checkOutput("arst pc", id_pc, 32'h0);
        #3 rst_n = 1'b1;
        applyStimulus(1, I_ADD7, 32'h700, 1, 0); stepClock();
        checkOutput("after rst rd", 32'(rd), 32'd7);
        applyStimulus(0, 32'h0, 32'h0, 1, 0); stepClock();
        stepClock();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
